mem_stage: RTL and testbench

//  MEM stage of the 5-stage pipeline. Consumes EX/MEM register outputs and performs loads/stores over a ready-handshake data port.

---
 rtl/calab_pkg.sv | 13 +
 rtl/mem_wb_reg.sv | 62 ++++++
 rtl/mem_stage.sv | 138 +++++++++++++
 tb/tb_mem_stage.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/calab_pkg.sv
// Shared definitions for the calab pipeline: MEM-stage state encoding and
// common widths/defaults.
package calab_pkg;

  localparam int unsigned REG_ADDR_W    = 5;
  localparam int unsigned MEM_BASE_DFLT = 1024;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; bubble_i loads an all-zero (no-writeback) entry.
module mem_wb_reg
  import calab_pkg::*;
#(
  parameter int unsigned len = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  bubble_i,
  input  logic                  wb_en_i,
  input  logic                  mem_read_i,
  input  logic [len-1:0]        pc_i,
  input  logic [len-1:0]        instruction_i,
  input  logic [len-1:0]        alu_result_i,
  input  logic [len-1:0]        mem_data_i,
  input  logic [REG_ADDR_W-1:0] dest_i,
  output logic                  wb_en_o,
  output logic                  mem_read_o,
  output logic [len-1:0]        pc_o,
  output logic [len-1:0]        instruction_o,
  output logic [len-1:0]        alu_result_o,
  output logic [len-1:0]        mem_data_o,
  output logic [REG_ADDR_W-1:0] dest_o
);

  logic                  wb_en_q;
  logic                  mem_read_q;
  logic [len-1:0]        pc_q;
  logic [len-1:0]        instruction_q;
  logic [len-1:0]        alu_result_q;
  logic [len-1:0]        mem_data_q;
  logic [REG_ADDR_W-1:0] dest_q;

  always_ff @(posedge clock) begin
    if (reset || bubble_i) begin
      wb_en_q       <= 1'b0;
      mem_read_q    <= 1'b0;
      pc_q          <= '0;
      instruction_q <= '0;
      alu_result_q  <= '0;
      mem_data_q    <= '0;
      dest_q        <= '0;
    end else begin
      wb_en_q       <= wb_en_i;
      mem_read_q    <= mem_read_i;
      pc_q          <= pc_i;
      instruction_q <= instruction_i;
      alu_result_q  <= alu_result_i;
      mem_data_q    <= mem_data_i;
      dest_q        <= dest_i;
    end
  end

  assign wb_en_o       = wb_en_q;
  assign mem_read_o    = mem_read_q;
  assign pc_o          = pc_q;
  assign instruction_o = instruction_q;
  assign alu_result_o  = alu_result_q;
  assign mem_data_o    = mem_data_q;
  assign dest_o        = dest_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage: issues loads/stores over a ready handshake, freezes upstream
// while an access is outstanding, aborts via watchdog, and drives MEM/WB.
module mem_stage
  import calab_pkg::*;
#(
  parameter int unsigned len      = 32,
  parameter int unsigned MEM_BASE = MEM_BASE_DFLT,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wb_en,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [len-1:0]        pc,
  input  logic [len-1:0]        instruction,
  input  logic [len-1:0]        alu_result,
  input  logic [len-1:0]        src2_val,
  input  logic [REG_ADDR_W-1:0] dest,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [len-1:0]        mem_addr,
  output logic [len-1:0]        mem_wdata,
  input  logic [len-1:0]        mem_rdata,
  input  logic                  mem_ready,
  output logic                  freeze,
  output logic                  mem_err,
  output logic                  wb_en_out,
  output logic                  mem_read_out,
  output logic [len-1:0]        pc_out,
  output logic [len-1:0]        instruction_out,
  output logic [len-1:0]        alu_result_out,
  output logic [len-1:0]        mem_data_out,
  output logic [REG_ADDR_W-1:0] dest_out
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  mem_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mem_req_q;
  logic             mem_we_q;
  logic [len-1:0]   mem_addr_q;
  logic [len-1:0]   mem_wdata_q;
  logic             mem_err_q;

  logic             is_mem_c;
  logic             rd_eff_c;
  logic             timeout_c;
  logic             complete_c;
  logic             abort_c;
  logic             freeze_c;
  logic [len-1:0]   addr_c;
  logic [len-1:0]   wb_data_c;

  // A simultaneous read+write is treated as a store.
  assign is_mem_c   = mem_read | mem_write;
  assign rd_eff_c   = mem_read & ~mem_write;
  assign addr_c     = (alu_result - len'(MEM_BASE)) & ~len'(3);

  assign timeout_c  = (cnt_q == CNT_W'(TIMEOUT));
  assign complete_c = (state_q == MEM_WAIT) & mem_ready;
  assign abort_c    = (state_q == MEM_WAIT) & ~mem_ready & timeout_c;
  assign freeze_c   = ((state_q == MEM_IDLE) & is_mem_c) |
                      ((state_q == MEM_WAIT) & ~mem_ready & ~timeout_c);
  assign wb_data_c  = (complete_c & rd_eff_c) ? mem_rdata : '0;

  // Access FSM, watchdog counter and data-port latches.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= MEM_IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      case (state_q)
        MEM_IDLE: begin
          if (is_mem_c) begin
            state_q     <= MEM_WAIT;
            cnt_q       <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= mem_write;
            mem_addr_q  <= addr_c;
            mem_wdata_q <= src2_val;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state_q   <= MEM_IDLE;
            mem_req_q <= 1'b0;
          end else if (timeout_c) begin
            state_q   <= MEM_IDLE;
            mem_req_q <= 1'b0;
            mem_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q   <= MEM_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Aborted accesses retire as bubbles so they never write back.
  mem_wb_reg #(.len(len)) u_mem_wb (
    .clock         (clock),
    .reset         (reset),
    .bubble_i      (freeze_c | abort_c),
    .wb_en_i       (wb_en),
    .mem_read_i    (rd_eff_c),
    .pc_i          (pc),
    .instruction_i (instruction),
    .alu_result_i  (alu_result),
    .mem_data_i    (wb_data_c),
    .dest_i        (dest),
    .wb_en_o       (wb_en_out),
    .mem_read_o    (mem_read_out),
    .pc_o          (pc_out),
    .instruction_o (instruction_out),
    .alu_result_o  (alu_result_out),
    .mem_data_o    (mem_data_out),
    .dest_o        (dest_out)
  );

  assign freeze    = freeze_c;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through vector table plus hand-written
// load/store/back-to-back/timeout/reset sequences.
module tb_mem_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_en, mem_read, mem_write;
  logic [31:0] pc, instruction, alu_result, src2_val;
  logic [4:0]  dest;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready, freeze, mem_err;
  logic        wb_en_out, mem_read_out;
  logic [31:0] pc_out, instruction_out, alu_result_out, mem_data_out;
  logic [4:0]  dest_out;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mem_stage #(.len(32), .MEM_BASE(1024), .TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .wb_en(wb_en), .mem_read(mem_read),
    .mem_write(mem_write), .pc(pc), .instruction(instruction),
    .alu_result(alu_result), .src2_val(src2_val), .dest(dest),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .freeze(freeze), .mem_err(mem_err), .wb_en_out(wb_en_out),
    .mem_read_out(mem_read_out), .pc_out(pc_out),
    .instruction_out(instruction_out), .alu_result_out(alu_result_out),
    .mem_data_out(mem_data_out), .dest_out(dest_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_alu(input logic wbe, input logic [31:0] p, input logic [31:0] ins,
                         input logic [31:0] alu, input logic [4:0] d);
    wb_en = wbe; mem_read = 1'b0; mem_write = 1'b0;
    pc = p; instruction = ins; alu_result = alu; src2_val = 32'h0; dest = d;
  endtask

  // Runs one memory op entered from IDLE; ready is raised after n_wait
  // non-ready WAIT cycles. Called at posedge+1, returns at posedge+1.
  task automatic mem_op(input string tag, input logic rd, input logic wr, input logic wbe,
                        input logic [31:0] p, input logic [31:0] alu, input logic [31:0] sv,
                        input logic [4:0] d, input int n_wait, input logic [31:0] rdat,
                        input logic [31:0] e_addr, input logic e_we, input int e_frz,
                        input logic e_rdout, input logic [31:0] e_data);
    int frz = 0;
    mem_read = rd; mem_write = wr; wb_en = wbe; pc = p; instruction = p ^ 32'h13;
    alu_result = alu; src2_val = sv; dest = d; mem_ready = 1'b0; mem_rdata = 32'h0;
    #3;
    chk({tag, "_req_before"}, 32'(mem_req), 32'd0);
    if (freeze) frz++;
    step();
    chk({tag, "_req"}, 32'(mem_req), 32'd1);
    chk({tag, "_addr"}, mem_addr, e_addr);
    chk({tag, "_we"}, 32'(mem_we), 32'(e_we));
    if (e_we) chk({tag, "_wdata"}, mem_wdata, sv);
    chk({tag, "_bubble"}, 32'(wb_en_out), 32'd0);
    for (int w = 0; w < 20; w++) begin
      if (w == n_wait) begin
        mem_ready = 1'b1;
        mem_rdata = rdat;
      end
      #3;
      if (freeze) frz++;
      step();
      if (w == n_wait) break;
      chk({tag, "_wait_bubble"}, pc_out, 32'd0);
    end
    mem_ready = 1'b0; mem_rdata = 32'h0;
    mem_read = 1'b0; mem_write = 1'b0;
    chk({tag, "_freeze_cycles"}, 32'(frz), 32'(e_frz));
    chk({tag, "_req_done"}, 32'(mem_req), 32'd0);
    chk({tag, "_pc_out"}, pc_out, p);
    chk({tag, "_wb_en_out"}, 32'(wb_en_out), 32'(wbe));
    chk({tag, "_mem_read_out"}, 32'(mem_read_out), 32'(e_rdout));
    chk({tag, "_mem_data_out"}, mem_data_out, e_data);
    chk({tag, "_dest_out"}, 32'(dest_out), 32'(d));
  endtask

  typedef struct {
    logic        wbe;
    logic [31:0] p;
    logic [31:0] ins;
    logic [31:0] alu;
    logic [4:0]  d;
    logic        e_wb;
    logic [31:0] e_pc;
    logic [31:0] e_alu;
    logic [4:0]  e_dest;
  } alu_vec_t;

  alu_vec_t vecs[4];

  initial begin
    int frz;
    int waits;

    vecs[0] = '{1'b1, 32'h100, 32'h0050_0293, 32'h2A,        5'd5,  1'b1, 32'h100, 32'h2A,        5'd5};
    vecs[1] = '{1'b0, 32'h104, 32'h0000_0013, 32'hFFFF_FFFF, 5'd0,  1'b0, 32'h104, 32'hFFFF_FFFF, 5'd0};
    vecs[2] = '{1'b1, 32'h108, 32'h4000_0F93, 32'h400,       5'd31, 1'b1, 32'h108, 32'h400,       5'd31};
    vecs[3] = '{1'b1, 32'h10C, 32'h0010_0113, 32'h0,         5'd2,  1'b1, 32'h10C, 32'h0,         5'd2};

    reset = 1'b1; mem_ready = 1'b0; mem_rdata = 32'h0;
    set_alu(1'b1, 32'hABC, 32'h1234, 32'h77, 5'd9);
    step(); step();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    chk("rst_wb_en_out", 32'(wb_en_out), 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_alu_out", alu_result_out, 32'd0);
    chk("rst_freeze", 32'(freeze), 32'd0);
    reset = 1'b0;

    // Non-memory instructions pass through in one cycle.
    for (int i = 0; i < 4; i++) begin
      set_alu(vecs[i].wbe, vecs[i].p, vecs[i].ins, vecs[i].alu, vecs[i].d);
      #3;
      chk($sformatf("alu%0d_freeze", i), 32'(freeze), 32'd0);
      step();
      chk($sformatf("alu%0d_wb_en_out", i), 32'(wb_en_out), 32'(vecs[i].e_wb));
      chk($sformatf("alu%0d_pc_out", i), pc_out, vecs[i].e_pc);
      chk($sformatf("alu%0d_alu_out", i), alu_result_out, vecs[i].e_alu);
      chk($sformatf("alu%0d_dest_out", i), 32'(dest_out), 32'(vecs[i].e_dest));
      chk($sformatf("alu%0d_instr_out", i), instruction_out, vecs[i].ins);
      chk($sformatf("alu%0d_mem_data_out", i), mem_data_out, 32'd0);
      chk($sformatf("alu%0d_req", i), 32'(mem_req), 32'd0);
    end

    // Load 1032 -> addr 8, three non-ready WAIT cycles, freeze for 4.
    mem_op("load", 1'b1, 1'b0, 1'b1, 32'h200, 32'd1032, 32'h0, 5'd7, 3, 32'hDEAD_BEEF,
           32'd8, 1'b0, 4, 1'b1, 32'hDEAD_BEEF);
    set_alu(1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    step();

    // Store 1030 -> addr 4, one non-ready WAIT cycle, freeze for 2.
    mem_op("store", 1'b0, 1'b1, 1'b0, 32'h300, 32'd1030, 32'h55, 5'd0, 1, 32'h0,
           32'd4, 1'b1, 2, 1'b0, 32'h0);
    set_alu(1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    step();

    // Back-to-back: minimum-latency load, then read+write (store wins) wrapping below MEM_BASE.
    mem_op("b2b_load", 1'b1, 1'b0, 1'b1, 32'h400, 32'd1280, 32'h0, 5'd3, 0, 32'h1234_5678,
           32'h100, 1'b0, 1, 1'b1, 32'h1234_5678);
    mem_op("b2b_rw", 1'b1, 1'b1, 1'b0, 32'h404, 32'd1021, 32'hCAFE_F00D, 5'd4, 2, 32'hFFFF_FFFF,
           32'hFFFF_FFFC, 1'b1, 3, 1'b0, 32'h0);
    set_alu(1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    step();
    chk("b2b_after_pc_out", pc_out, 32'h0);

    // Timeout: never ready, abort after 5 WAIT cycles.
    wb_en = 1'b1; mem_read = 1'b1; mem_write = 1'b0; pc = 32'h500; instruction = 32'h513;
    alu_result = 32'd1100; src2_val = 32'h0; dest = 5'd8; mem_ready = 1'b0;
    frz = 0; waits = 0;
    #3;
    if (freeze) frz++;
    step();
    for (int c = 0; c < 20 && mem_req; c++) begin
      waits++;
      #3;
      if (freeze) frz++;
      step();
    end
    mem_read = 1'b0;
    chk("to_wait_cycles", 32'(waits), 32'd5);
    chk("to_freeze_cycles", 32'(frz), 32'd5);
    chk("to_mem_err", 32'(mem_err), 32'd1);
    chk("to_wb_en_out", 32'(wb_en_out), 32'd0);
    chk("to_pc_out", pc_out, 32'd0);

    set_alu(1'b1, 32'h600, 32'h0070_0393, 32'h99, 5'd7);
    #3;
    chk("post_to_freeze", 32'(freeze), 32'd0);
    step();
    chk("post_to_wb_en_out", 32'(wb_en_out), 32'd1);
    chk("post_to_alu_out", alu_result_out, 32'h99);
    chk("post_to_mem_err_sticky", 32'(mem_err), 32'd1);

    // Reset held 2 cycles while an access is in WAIT.
    wb_en = 1'b1; mem_read = 1'b1; pc = 32'h700; alu_result = 32'd1040; dest = 5'd9;
    step();
    chk("rw_req_in_wait", 32'(mem_req), 32'd1);
    reset = 1'b1; mem_read = 1'b0; wb_en = 1'b0;
    step(); step();
    chk("rw_mem_req", 32'(mem_req), 32'd0);
    chk("rw_mem_err", 32'(mem_err), 32'd0);
    chk("rw_mem_addr", mem_addr, 32'd0);
    chk("rw_wb_en_out", 32'(wb_en_out), 32'd0);
    chk("rw_pc_out", pc_out, 32'd0);
    chk("rw_freeze", 32'(freeze), 32'd0);
    reset = 1'b0;
    set_alu(1'b1, 32'h800, 32'h13, 32'h5, 5'd1);
    #3;
    chk("rw_resume_freeze", 32'(freeze), 32'd0);
    step();
    chk("rw_resume_req", 32'(mem_req), 32'd0);
    chk("rw_resume_pc_out", pc_out, 32'h800);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
